// File: rtl/gpu_prefetchq.sv
// Instruction prefetch queue: fetches program words ahead of execution into a
// halfword FIFO and hands 16-bit instructions with their PC to the decoder.
module gpu_prefetchq #(
  parameter int FETCH_W = 32,
  parameter int DEPTH   = 2,
  parameter int PC_W    = 24
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 go,
  input  logic                                 big_instr,
  input  logic                                 jump,
  input  logic [PC_W-1:0]                      jump_pc,
  output logic                                 progreq,
  output logic [PC_W-$clog2(FETCH_W/8)-1:0]    progaddr,
  input  logic                                 progack,
  input  logic [FETCH_W-1:0]                   prog_data,
  output logic                                 pabort,
  output logic                                 insrdy,
  output logic [15:0]                          instruction,
  output logic [PC_W-1:0]                      ins_pc,
  input  logic                                 insack,
  input  logic                                 single_step,
  input  logic                                 single_go,
  output logic [$clog2(DEPTH*FETCH_W/16):0]    level
);

  localparam int HPW = FETCH_W / 16;
  localparam int FB  = $clog2(FETCH_W / 8);
  localparam int CAP = DEPTH * HPW;
  localparam int PW  = $clog2(CAP);
  localparam int LW  = PW + 1;
  localparam int SKW = $clog2(HPW);
  localparam int AW  = PC_W - FB;

  logic [15:0]     mem [CAP];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [AW-1:0]   fa;
  logic            inflight;
  logic [SKW-1:0]  skip;
  logic [PC_W-1:0] head_pc;
  logic            token;

  logic            accept, pop, req_set, space_ok;
  logic [LW-1:0]   push_n, level_next;
  logic [15:0]     hw [HPW];
  logic            unused_pc_bit;

  assign unused_pc_bit = jump_pc[0];

  assign progreq     = inflight;
  assign progaddr    = fa;
  assign pabort      = jump & inflight;
  assign ins_pc      = head_pc;
  assign insrdy      = (level != '0) & (~single_step | token);
  assign instruction = (level != '0) ? mem[rd_ptr] : 16'h0;

  assign accept     = progack & inflight & ~jump;
  assign pop        = insrdy & insack;
  assign push_n     = accept ? (LW'(HPW) - LW'(skip)) : '0;
  assign level_next = level + push_n - LW'(pop);
  // Space is judged on the post-update level so a request can stay up across an ack edge.
  assign space_ok   = (LW'(CAP) - level_next) >= LW'(HPW);
  assign req_set    = go & ~jump & (~inflight | accept) & space_ok;

  always_comb begin
    for (int k = 0; k < HPW; k++) begin
      hw[k] = big_instr ? prog_data[FETCH_W-1-16*k -: 16] : prog_data[16*k +: 16];
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < HPW; j++) begin
      if (accept && (LW'(j) < push_n)) begin
        mem[wr_ptr + PW'(j)] <= hw[SKW'(j) + skip];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      fa       <= '0;
      inflight <= 1'b0;
      skip     <= '0;
      head_pc  <= '0;
      token    <= 1'b0;
    end else if (jump) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      fa       <= jump_pc[PC_W-1:FB];
      skip     <= jump_pc[FB-1:1];
      head_pc  <= {jump_pc[PC_W-1:1], 1'b0};
      inflight <= 1'b0;
      token    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(push_n);
        fa     <= fa + AW'(1);
        skip   <= '0;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        head_pc <= head_pc + PC_W'(2);
      end
      level    <= level_next;
      inflight <= req_set | (inflight & ~progack);
      token    <= single_go | (token & ~pop);
    end
  end

endmodule

// File: tb/tb_gpu_prefetchq.sv
// Directed bench for gpu_prefetchq: a 32-bit/depth-2 instance for most scenarios
// and a 64-bit instance for halfword-accurate jump entry.
module tb_gpu_prefetchq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        go = 0, big_instr = 0, jump = 0, progack = 0, insack = 0;
  logic        single_step = 0, single_go = 0;
  logic [23:0] jump_pc = '0;
  logic [31:0] prog_data = '0;
  logic        progreq, pabort, insrdy;
  logic [21:0] progaddr;
  logic [15:0] instruction;
  logic [23:0] ins_pc;
  logic [2:0]  level;

  logic        go_b = 0, big_b = 0, jump_b = 0, progack_b = 0, insack_b = 0;
  logic [23:0] jump_pc_b = '0;
  logic [63:0] prog_data_b = '0;
  logic        progreq_b, pabort_b, insrdy_b;
  logic [20:0] progaddr_b;
  logic [15:0] instruction_b;
  logic [23:0] ins_pc_b;
  logic [3:0]  level_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpu_prefetchq #(.FETCH_W(32), .DEPTH(2), .PC_W(24)) u_dut (
    .clk(clk), .reset_n(reset_n), .go(go), .big_instr(big_instr),
    .jump(jump), .jump_pc(jump_pc), .progreq(progreq), .progaddr(progaddr),
    .progack(progack), .prog_data(prog_data), .pabort(pabort), .insrdy(insrdy),
    .instruction(instruction), .ins_pc(ins_pc), .insack(insack),
    .single_step(single_step), .single_go(single_go), .level(level)
  );

  gpu_prefetchq #(.FETCH_W(64), .DEPTH(2), .PC_W(24)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .go(go_b), .big_instr(big_b),
    .jump(jump_b), .jump_pc(jump_pc_b), .progreq(progreq_b), .progaddr(progaddr_b),
    .progack(progack_b), .prog_data(prog_data_b), .pabort(pabort_b), .insrdy(insrdy_b),
    .instruction(instruction_b), .ins_pc(ins_pc_b), .insack(insack_b),
    .single_step(1'b0), .single_go(1'b0), .level(level_b)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic g, input logic jmp, input logic [23:0] jpc,
                               input logic ack, input logic [31:0] data,
                               input logic iack, input logic ss, input logic sgo);
    go = g; jump = jmp; jump_pc = jpc; progack = ack; prog_data = data;
    insack = iack; single_step = ss; single_go = sgo;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    checkOutput("rst_progreq", progreq, 0);
    checkOutput("rst_pabort", pabort, 0);
    checkOutput("rst_insrdy", insrdy, 0);
    checkOutput("rst_instr", instruction, 0);
    checkOutput("rst_ins_pc", ins_pc, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_progaddr", progaddr, 0);
    checkOutput("rst_level_b", level_b, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    big_instr = 1'b1;

    // Basic fetch and delivery, most-significant halfword first
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); tick;
    checkOutput("req_rise", progreq, 1);
    checkOutput("req_addr0", progaddr, 0);
    applyStimulus(1, 0, 0, 1, 32'h1111_2222, 0, 0, 0); tick;
    checkOutput("t1_level2", level, 2);
    checkOutput("t1_insrdy", insrdy, 1);
    checkOutput("t1_instr0", instruction, 16'h1111);
    checkOutput("t1_pc0", ins_pc, 0);
    checkOutput("t1_b2b_req", progreq, 1);
    checkOutput("t1_addr1", progaddr, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0); tick;
    checkOutput("t1_level1", level, 1);
    checkOutput("t1_instr1", instruction, 16'h2222);
    checkOutput("t1_pc2", ins_pc, 2);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0); tick;
    checkOutput("t1_level0", level, 0);
    checkOutput("t1_empty_rdy", insrdy, 0);
    checkOutput("t1_empty_instr", instruction, 0);
    checkOutput("t1_pc4", ins_pc, 4);

    // Fill to capacity, then drain until a new request is allowed
    applyStimulus(1, 0, 0, 1, 32'h0000_000A, 0, 0, 0); tick;
    checkOutput("fill_level2", level, 2);
    applyStimulus(1, 0, 0, 1, 32'h0000_000B, 0, 0, 0); tick;
    checkOutput("fill_level4", level, 4);
    checkOutput("fill_noreq", progreq, 0);
    checkOutput("fill_addr3", progaddr, 3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); tick;
    checkOutput("fill_hold", progreq, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0); tick;
    checkOutput("fill_level3", level, 3);
    checkOutput("fill_noreq3", progreq, 0);
    checkOutput("fill_instr", instruction, 16'h000A);
    checkOutput("fill_pc6", ins_pc, 6);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0); tick;
    checkOutput("fill_level2b", level, 2);
    checkOutput("fill_rereq", progreq, 1);
    checkOutput("fill_pc8", ins_pc, 8);

    // Jump coincident with progack: data dropped
    applyStimulus(1, 1, 24'h000040, 1, 32'hDEAD_BEEF, 0, 0, 0);
    checkOutput("jack_pabort", pabort, 1);
    tick;
    checkOutput("jack_level", level, 0);
    checkOutput("jack_noreq", progreq, 0);
    checkOutput("jack_pc", ins_pc, 24'h40);
    checkOutput("jack_rdy", insrdy, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); tick;
    checkOutput("jack_req", progreq, 1);
    checkOutput("jack_addr", progaddr, 22'h10);

    // Address and PC wrap
    applyStimulus(1, 1, 24'hFFFFFC, 0, 0, 0, 0, 0);
    checkOutput("wrap_pabort", pabort, 1);
    tick;
    checkOutput("wrap_noreq", progreq, 0);
    checkOutput("wrap_fa", progaddr, 22'h3FFFFF);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); tick;
    checkOutput("wrap_req", progreq, 1);
    applyStimulus(1, 0, 0, 1, 32'h5555_6666, 0, 0, 0); tick;
    checkOutput("wrap_addr0", progaddr, 0);
    checkOutput("wrap_instr", instruction, 16'h5555);
    checkOutput("wrap_pc_fc", ins_pc, 24'hFFFFFC);
    applyStimulus(0, 0, 0, 1, 32'h7777_8888, 1, 0, 0); tick;
    checkOutput("wrap_level3", level, 3);
    checkOutput("wrap_pc_fe", ins_pc, 24'hFFFFFE);
    checkOutput("wrap_instr2", instruction, 16'h6666);
    checkOutput("wrap_noreq2", progreq, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0); tick;
    checkOutput("wrap_pc_00", ins_pc, 0);
    checkOutput("wrap_instr3", instruction, 16'h7777);

    // Single-step: one instruction per single_go pulse
    applyStimulus(0, 1, 24'h000100, 0, 0, 0, 0, 0);
    checkOutput("ss_pabort_idle", pabort, 0);
    tick;
    checkOutput("ss_jlevel", level, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0); tick;
    checkOutput("ss_addr", progaddr, 22'h40);
    applyStimulus(1, 0, 0, 1, 32'h0001_0002, 0, 1, 0); tick;
    applyStimulus(0, 0, 0, 1, 32'h0003_0004, 0, 1, 0); tick;
    checkOutput("ss_level4", level, 4);
    checkOutput("ss_blocked", insrdy, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0); tick;
    checkOutput("ss_noack", level, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1); tick;
    checkOutput("ss_rdy", insrdy, 1);
    checkOutput("ss_instr", instruction, 16'h0001);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0); tick;
    checkOutput("ss_level3", level, 3);
    checkOutput("ss_one_only", insrdy, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1); tick;
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1); tick;
    checkOutput("ss_level2", level, 2);
    checkOutput("ss_token_kept", insrdy, 1);
    checkOutput("ss_instr3", instruction, 16'h0003);
    checkOutput("ss_pc", ins_pc, 24'h104);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // 64-bit instance: jump into the middle of a word, little-halfword order
    go_b = 1; tick;
    checkOutput("b_req", progreq_b, 1);
    checkOutput("b_addr0", progaddr_b, 0);
    jump_b = 1; jump_pc_b = 24'h000106; #1;
    checkOutput("b_pabort", pabort_b, 1);
    tick;
    jump_b = 0;
    checkOutput("b_noreq", progreq_b, 0);
    checkOutput("b_fa", progaddr_b, 21'h20);
    tick;
    checkOutput("b_rereq", progreq_b, 1);
    progack_b = 1; prog_data_b = 64'h4444_3333_2222_1111; tick;
    progack_b = 0; go_b = 0;
    checkOutput("b_level1", level_b, 1);
    checkOutput("b_instr", instruction_b, 16'h4444);
    checkOutput("b_pc", ins_pc_b, 24'h106);
    checkOutput("b_rdy", insrdy_b, 1);
    checkOutput("b_req_more", progreq_b, 1);

    // Asynchronous reset in the middle of a request
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_req", progreq_b, 0);
    checkOutput("arst_pabort", pabort_b, 0);
    checkOutput("arst_level", level_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
